uart_rx: RTL and testbench

//  Serial receiver that consumes the UART TX line (Tx_out) and rebuilds the parallel byte.

---
 rtl/uart_rx_if.sv | 30 +++
 rtl/uart_rx.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: signal bundle between a UART receiver and its user.
//   rx_in          serial line into the receiver (asynchronous to clk)
//   PAR_EN         1 = frames carry a parity bit
//   parity_type    0 = even, 1 = odd
//   p_data_out     last good byte received
//   data_valid_out 1-cycle pulse, p_data_out updated
//   par_err        1-cycle pulse, parity mismatch (byte dropped)
//   stp_err        1-cycle pulse, stop bit sampled low (byte dropped)
//   busy_rx        high from start detection until return to idle
// master = line driver / consumer side, slave = the receiver.
interface uart_rx_if;
  logic       rx_in;
  logic       PAR_EN;
  logic       parity_type;
  logic [7:0] p_data_out;
  logic       data_valid_out;
  logic       par_err;
  logic       stp_err;
  logic       busy_rx;

  modport master (
    output rx_in, PAR_EN, parity_type,
    input  p_data_out, data_valid_out, par_err, stp_err, busy_rx
  );

  modport slave (
    input  rx_in, PAR_EN, parity_type,
    output p_data_out, data_valid_out, par_err, stp_err, busy_rx
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver. Frame = start(0), 8 data bits LSB
// first, optional parity, stop(1); line idles high.
// Ports: clk (rising edge), rst (synchronous, active high), bus (uart_rx_if
// slave modport: rx_in, PAR_EN, parity_type in; p_data_out, data_valid_out,
// par_err, stp_err, busy_rx out).
// Build option: define UART_RX_MAJORITY_EN to decide each bit by majority of
// three mid-bit samples; otherwise a single mid-bit sample is used and every
// latency is one clock shorter.
//
// state  | meaning
// IDLE   | waiting for a falling edge on an armed (previously high) line
// START  | validating the start bit; a high decision aborts as a glitch
// DATA   | shifting in 8 data bits, LSB first
// PARITY | checking the parity bit against the latched parity type
// STOP   | deciding the stop bit mid-bit, then reporting the frame result
module uart_rx #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_W     = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int EW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_W);
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = OVERSAMPLE / 2 + 1;
`else
  localparam int DEC = OVERSAMPLE / 2;
`endif
  localparam logic [EW-1:0] DEC_C    = EW'(DEC);
  localparam logic [EW-1:0] LAST_C   = EW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q;
  logic              sync1_q;
  logic              rxs_q;
  logic [1:0]        vld_q;
  logic [EW-1:0]     edge_q;
  logic [BW-1:0]     bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_en_q;
  logic              ptype_q;
  logic              perr_q;
  logic              armed_q;
  logic [7:0]        data_q;
  logic              dv_q;
  logic              par_err_q;
  logic              stp_err_q;
  logic              busy_q;
  logic              bit_dec;

`ifdef UART_RX_MAJORITY_EN
  logic s_lo_q;
  logic s_mid_q;

  always_comb begin
    bit_dec = (s_lo_q & s_mid_q) | (s_lo_q & rxs_q) | (s_mid_q & rxs_q);
  end
`else
  always_comb begin
    bit_dec = rxs_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      rxs_q     <= 1'b1;
      vld_q     <= '0;
      state_q   <= S_IDLE;
      edge_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      ptype_q   <= 1'b0;
      perr_q    <= 1'b0;
      armed_q   <= 1'b0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      s_lo_q    <= 1'b0;
      s_mid_q   <= 1'b0;
`endif
    end else begin
      sync1_q   <= bus.rx_in;
      rxs_q     <= sync1_q;
      // The synchroniser flops come out of reset at 1 regardless of the line;
      // arming waits until they have been refilled from the real line, so a
      // reset in the middle of a low bit cannot look like idle-then-start.
      vld_q     <= {vld_q[0], 1'b1};
      dv_q      <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;

`ifdef UART_RX_MAJORITY_EN
      if (state_q != S_IDLE) begin
        if (edge_q == EW'(OVERSAMPLE / 2 - 1)) s_lo_q  <= rxs_q;
        if (edge_q == EW'(OVERSAMPLE / 2))     s_mid_q <= rxs_q;
      end
`endif

      case (state_q)
        S_IDLE: begin
          if (rxs_q && vld_q[1]) armed_q <= 1'b1;
          if (armed_q && !rxs_q) begin
            state_q  <= S_START;
            edge_q   <= '0;
            busy_q   <= 1'b1;
            par_en_q <= bus.PAR_EN;
            ptype_q  <= bus.parity_type;
            perr_q   <= 1'b0;
          end
        end

        S_START: begin
          if (edge_q == DEC_C && bit_dec) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            armed_q <= 1'b0;
            edge_q  <= '0;
          end else if (edge_q == LAST_C) begin
            state_q <= S_DATA;
            edge_q  <= '0;
            bit_q   <= '0;
          end else begin
            edge_q <= edge_q + 1'b1;
          end
        end

        S_DATA: begin
          if (edge_q == DEC_C) shift_q[bit_q] <= bit_dec;
          if (edge_q == LAST_C) begin
            edge_q <= '0;
            if (bit_q == BIT_LAST) state_q <= par_en_q ? S_PARITY : S_STOP;
            else                   bit_q   <= bit_q + 1'b1;
          end else begin
            edge_q <= edge_q + 1'b1;
          end
        end

        S_PARITY: begin
          if (edge_q == DEC_C) perr_q <= (bit_dec != (^shift_q ^ ptype_q));
          if (edge_q == LAST_C) begin
            state_q <= S_STOP;
            edge_q  <= '0;
          end else begin
            edge_q <= edge_q + 1'b1;
          end
        end

        S_STOP: begin
          // Leaving at mid-stop lets a back-to-back start bit be caught.
          // A low stop bit also disarms, so a stuck-low line cannot retrigger.
          if (edge_q == DEC_C) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            edge_q  <= '0;
            armed_q <= bit_dec;
            if (!bit_dec) begin
              stp_err_q <= 1'b1;
            end else if (perr_q) begin
              par_err_q <= 1'b1;
            end else begin
              data_q <= shift_q[7:0];
              dv_q   <= 1'b1;
            end
          end else begin
            edge_q <= edge_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          edge_q  <= '0;
        end
      endcase
    end
  end

  assign bus.p_data_out     = data_q;
  assign bus.data_valid_out = dv_q;
  assign bus.par_err        = par_err_q;
  assign bus.stp_err        = stp_err_q;
  assign bus.busy_rx        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives UART frames into uart_rx and compares every output pulse
// (kind, cycle, byte) against a frame-level reference model.
module tb_uart_rx;
  localparam int OS = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 80;
`else
  localparam int LAT = 79;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  uart_rx_if bus ();

  uart_rx #(.OVERSAMPLE(OS), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int kind;   // 1 = data_valid, 2 = par_err, 3 = stp_err
    int data;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  logic [7:0] last_good = 8'h00;

  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      e.cyc = cyc;
      if (bus.data_valid_out) begin
        e.kind = 1; e.data = int'(bus.p_data_out); obs_q.push_back(e);
      end
      if (bus.par_err) begin
        e.kind = 2; e.data = 0; obs_q.push_back(e);
      end
      if (bus.stp_err) begin
        e.kind = 3; e.data = 0; obs_q.push_back(e);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Parity bit a correct transmitter would send.
  function automatic bit good_parity(input logic [7:0] d, input bit pt);
    return bit'(($countones(d) % 2) == 1) ^ pt;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; bus.rx_in = 1'b1;
    end
  endtask

  task automatic drive(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; bus.rx_in = v;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pen, input bit pt,
                            input bit pbit, input bit stopb, input int flip_slot);
    bit  bits[$];
    int  p;
    int  kind;
    ev_t e;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(stopb);
    bus.PAR_EN      = pen;
    bus.parity_type = pt;
    p = 0;
    for (int b = 0; b < bits.size(); b++) begin
      for (int s = 0; s < OS; s++) begin
        @(posedge clk); #1;
        bus.rx_in = ((b * OS + s) == flip_slot) ? ~bits[b] : bits[b];
        if (b == 0 && s == 0) p = cyc;
        // configuration changes mid-frame must be ignored
        if (b == 2 && s == 0) begin
          bus.PAR_EN      = 1'($urandom);
          bus.parity_type = 1'($urandom);
        end
      end
    end
    if (!stopb)                                kind = 3;
    else if (pen && pbit != good_parity(d, pt)) kind = 2;
    else                                       kind = 1;
    e.cyc  = p + 1 + LAT + (pen ? OS : 0);
    e.kind = kind;
    e.data = (kind == 1) ? int'(d) : 0;
    exp_q.push_back(e);
    if (kind == 1) last_good = d;
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, "_kind"},  obs_q[i].kind, exp_q[i].kind);
      chk({tag, "_cycle"}, obs_q[i].cyc,  exp_q[i].cyc);
      chk({tag, "_data"},  obs_q[i].data, exp_q[i].data);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, bus.data_valid_out, 1'b0);
    chk({tag, "_par"},   bus.par_err,        1'b0);
    chk({tag, "_stp"},   bus.stp_err,        1'b0);
    chk({tag, "_busy"},  bus.busy_rx,        1'b0);
    chk({tag, "_data"},  bus.p_data_out,     last_good);
  endtask

  initial begin
    logic [7:0] d;
    bit         pen, pt, pb;
    bus.rx_in       = 1'b1;
    bus.PAR_EN      = 1'b0;
    bus.parity_type = 1'b0;
    rst             = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;
    idle(10);

    // even parity, correct parity bit
    send_frame(8'hCC, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    idle(20);
    check_events("t1");
    chk("t1_pdata", bus.p_data_out, 8'hCC);

    // two frames back to back, no parity
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(20);
    check_events("t2");
    chk("t2_pdata", bus.p_data_out, 8'h55);

    // odd parity expected, wrong parity bit sent
    send_frame(8'hAA, 1'b1, 1'b1, 1'b0, 1'b1, -1);
    idle(20);
    check_events("t3");
    chk("t3_pdata", bus.p_data_out, last_good);

    // stop bit low, line stuck low afterwards
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    drive(1'b0, 40);
    chk("t4_busy_low", bus.busy_rx, 1'b0);
    idle(20);
    check_events("t4");
    chk("t4_pdata", bus.p_data_out, last_good);

    // 2-clock glitch must abort in START
    @(posedge clk); #1; bus.rx_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; bus.rx_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_busy_start", bus.busy_rx, 1'b1);
    idle(20);
    chk("t5_busy_end", bus.busy_rx, 1'b0);
    check_events("t5");
`ifdef UART_RX_MAJORITY_EN
    // one flipped mid-bit sample in data bit 2 is outvoted
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 3 * OS + 5);
    idle(20);
    check_events("t5_flip");
    chk("t5_flip_pdata", bus.p_data_out, 8'h96);
`endif

    // randomized frames: random config, occasional bad parity, random gaps
    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom);
      pen = 1'($urandom);
      pt  = 1'($urandom);
      pb  = good_parity(d, pt) ^ (($urandom % 4) == 0);
      send_frame(d, pen, pt, pb, 1'b1, -1);
      if (($urandom % 3) != 0) idle($urandom_range(1, 20));
    end
    idle(20);
    check_events("rand");
    chk("rand_pdata", bus.p_data_out, last_good);

    // reset during data bit 3 of 0xF0 (line low), line stays low afterwards
    drive(1'b0, 4 * OS + 4);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    last_good = 8'h00;
    obs_q.delete();
    check_quiet("t6_rst");
    drive(1'b0, 12);
    chk("t6_no_false_start", bus.busy_rx, 1'b0);
    idle(20);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(20);
    check_events("t6");
    chk("t6_pdata", bus.p_data_out, 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
